// File: rtl/rct_cfg.sv
// -----------------------------------------------------------------------------
// rct_cfg
//   Shared configuration for the rct mem_if / Wishbone bridges: bus and mask
//   widths, transaction-id layout, mem_if opcodes and status codes, the
//   bridge FSM state type and a helper that builds a request tid.
// -----------------------------------------------------------------------------
package rct_cfg;

    localparam int unsigned RCT_MEM_DATA_W   = 32;
    localparam int unsigned RCT_MEM_MASK_W   = RCT_MEM_DATA_W / 8;

    localparam int unsigned CPUNOC_TID_W     = 16;
    localparam int unsigned CPUNOC_TID_SRC_W = 4;
    localparam int unsigned CPUNOC_TID_SEQ_W = 8;

    localparam int unsigned RCT_OP_W         = 3;
    localparam logic [RCT_OP_W-1:0] RCT_OP_READ  = 3'b000;
    localparam logic [RCT_OP_W-1:0] RCT_OP_WRITE = 3'b001;

    localparam int unsigned RCT_STATUS_W     = 3;
    localparam logic [RCT_STATUS_W-1:0] RCT_STATUS_OK = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ACK,
        ST_ERR
    } w2m_state_e;

    // tid = {zero pad, source id, sequence number}
    function automatic logic [CPUNOC_TID_W-1:0] rct_make_tid(
        input logic [CPUNOC_TID_SRC_W-1:0] src,
        input logic [CPUNOC_TID_SEQ_W-1:0] seq
    );
        return {{(CPUNOC_TID_W - CPUNOC_TID_SRC_W - CPUNOC_TID_SEQ_W){1'b0}}, src, seq};
    endfunction

endpackage

// File: rtl/rct_w2m_bridge.sv
// -----------------------------------------------------------------------------
// rct_w2m_bridge
//   Wishbone B4 classic slave that converts each WB cycle into a single mem_if
//   request and returns the mem_if response as a one-cycle ack or err.
//   One transaction outstanding at a time; single clock domain.
//
//   Optional feature: define RCT_W2M_TIMEOUT_EN to enable a response watchdog
//   that ends a transaction with err after TIMEOUT_CYCLES cycles in RESP.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   wb_cyc_i / wb_stb_i    WB cycle and strobe
//   wb_addr_i, wb_we_i     byte address, write enable
//   wb_data_i, wb_sel_i    write data, byte selects
//   wb_ack_o / wb_err_o    one-cycle completion (mutually exclusive)
//   wb_data_o              read data, valid with wb_ack_o
//   mem_if_req_valid/ready request handshake
//   mem_if_req             {op, tid, addr, data, mask}
//   mem_if_resp_valid/ready response handshake
//   mem_if_resp            {status, tid, data}
// -----------------------------------------------------------------------------
module rct_w2m_bridge
    import rct_cfg::*;
#(
    parameter int unsigned BUS_WIDTH      = RCT_MEM_DATA_W,
    parameter int unsigned BUS_MASK       = RCT_MEM_MASK_W,
    parameter logic [3:0]  SRCID          = 4'h1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [BUS_WIDTH-1:0] wb_addr_i,
    input  logic                 wb_we_i,
    input  logic [BUS_WIDTH-1:0] wb_data_i,
    input  logic [BUS_MASK-1:0]  wb_sel_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [BUS_WIDTH-1:0] wb_data_o,

    output logic                 mem_if_req_valid,
    input  logic                 mem_if_req_ready,
    output logic [RCT_OP_W+CPUNOC_TID_W+2*BUS_WIDTH+BUS_MASK-1:0] mem_if_req,
    input  logic                 mem_if_resp_valid,
    output logic                 mem_if_resp_ready,
    input  logic [RCT_STATUS_W+CPUNOC_TID_W+BUS_WIDTH-1:0]        mem_if_resp
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rct_w2m_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    w2m_state_e                  state_q, state_d;

    logic [BUS_WIDTH-1:0]        addr_q;
    logic [BUS_WIDTH-1:0]        wdata_q;
    logic [BUS_MASK-1:0]         sel_q;
    logic                        we_q;
    logic                        capture;

    logic [CPUNOC_TID_SEQ_W-1:0] seq_q, seq_d;
    logic [CPUNOC_TID_W-1:0]     exp_tid_q, exp_tid_d;
    logic [BUS_WIDTH-1:0]        rdata_q, rdata_d;
    logic                        abort_q, abort_d;
    logic                        holdoff_q, holdoff_d;
    logic                        resp_ready_q, resp_ready_d;

    logic [CPUNOC_TID_W-1:0]     req_tid;
    logic [RCT_STATUS_W-1:0]     resp_status;
    logic [CPUNOC_TID_W-1:0]     resp_tid;
    logic [BUS_WIDTH-1:0]        resp_data;
    logic                        resp_hs;
    logic                        aborting;
    logic                        tmo_hit;

    assign {resp_status, resp_tid, resp_data} = mem_if_resp;
    assign req_tid  = rct_make_tid(SRCID, seq_q);
    assign resp_hs  = mem_if_resp_valid & resp_ready_q;
    // The master may drop cyc on the very cycle the response lands; treat
    // that the same as an earlier abort so no ack/err escapes.
    assign aborting = abort_q | ~wb_cyc_i;

`ifdef RCT_W2M_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Held at zero outside RESP, so it starts from zero on every entry.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ST_RESP) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_RESP) && !resp_hs &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        seq_d     = seq_q;
        exp_tid_d = exp_tid_q;
        abort_d   = abort_q;
        holdoff_d = 1'b0;
        rdata_d   = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (!holdoff_q && wb_cyc_i && wb_stb_i) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                abort_d = aborting;
                if (mem_if_req_ready) begin
                    seq_d     = seq_q + 1'b1;
                    exp_tid_d = req_tid;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                abort_d = aborting;
                if (resp_hs) begin
                    if (aborting) begin
                        state_d = ST_IDLE;
                    end else if (resp_tid == exp_tid_q && resp_status == RCT_STATUS_OK) begin
                        state_d = ST_ACK;
                        rdata_d = we_q ? '0 : resp_data;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (tmo_hit) begin
                    state_d = aborting ? ST_IDLE : ST_ERR;
                end
            end
            ST_ACK, ST_ERR: begin
                // Master drops stb in response to ack/err; skip one IDLE cycle
                // so the stale strobe is not taken as a new request.
                state_d   = ST_IDLE;
                holdoff_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Stray responses are drained in IDLE; REQ back-pressures them.
        resp_ready_d = (state_d == ST_IDLE) || (state_d == ST_RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            seq_q        <= '0;
            exp_tid_q    <= '0;
            rdata_q      <= '0;
            abort_q      <= 1'b0;
            holdoff_q    <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            exp_tid_q    <= exp_tid_d;
            rdata_q      <= rdata_d;
            abort_q      <= abort_d;
            holdoff_q    <= holdoff_d;
            resp_ready_q <= resp_ready_d;
            if (capture) begin
                addr_q  <= wb_addr_i;
                we_q    <= wb_we_i;
                wdata_q <= wb_we_i ? wb_data_i : '0;
                sel_q   <= wb_sel_i;
            end
        end
    end

    assign mem_if_req_valid  = (state_q == ST_REQ);
    assign mem_if_req        = mem_if_req_valid ?
                               {(we_q ? RCT_OP_WRITE : RCT_OP_READ), req_tid, addr_q, wdata_q, sel_q} :
                               '0;
    assign mem_if_resp_ready = resp_ready_q;

    assign wb_ack_o  = (state_q == ST_ACK);
    assign wb_err_o  = (state_q == ST_ERR);
    assign wb_data_o = wb_ack_o ? rdata_q : '0;

endmodule

// File: tb/tb_rct_w2m_bridge.sv
// -----------------------------------------------------------------------------
// tb_rct_w2m_bridge
//   Self-checking bench for rct_w2m_bridge: the bench plays WB master and
//   mem_if target. Expected requests and completions come from a transaction
//   level model (sequence counter modulo 256, field packing by rule).
//   Define RCT_W2M_TIMEOUT_EN to include the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_rct_w2m_bridge;

    localparam int unsigned TMO = 16;
    localparam logic [3:0]  SRC = 4'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata, wb_rdata;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err;
    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [86:0] req;
    logic [50:0] resp;

    always #5 clk = ~clk;

    rct_w2m_bridge #(
        .BUS_WIDTH      (32),
        .BUS_MASK       (4),
        .SRCID          (SRC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .wb_cyc_i          (wb_cyc),
        .wb_stb_i          (wb_stb),
        .wb_addr_i         (wb_addr),
        .wb_we_i           (wb_we),
        .wb_data_i         (wb_wdata),
        .wb_sel_i          (wb_sel),
        .wb_ack_o          (wb_ack),
        .wb_err_o          (wb_err),
        .wb_data_o         (wb_rdata),
        .mem_if_req_valid  (req_valid),
        .mem_if_req_ready  (req_ready),
        .mem_if_req        (req),
        .mem_if_resp_valid (resp_valid),
        .mem_if_resp_ready (resp_ready),
        .mem_if_resp       (resp)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned seq_m = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [86:0] model_req(input bit we, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s,
                                              input int unsigned seq);
        logic [7:0] seq8;
        seq8 = 8'(seq);
        return {(we ? 3'b001 : 3'b000), 4'h0, SRC, seq8, a, (we ? d : 32'h0), s};
    endfunction

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ack"}, 128'(wb_ack), 128'(1'b0));
        check_val({tag, "_err"}, 128'(wb_err), 128'(1'b0));
    endtask

    // abort_at: 0 none, 1 drop cyc in REQ, 2 drop cyc in RESP
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int unsigned stall, input int unsigned rdly,
                          input logic [2:0] status, input bit bad_tid, input logic [31:0] rdata,
                          input int unsigned abort_at);
        logic [86:0] exp_req;
        logic [15:0] tid;
        bit          ok, want_ack, want_err;
        exp_req  = model_req(we, addr, wdata, sel, seq_m);
        tid      = exp_req[83:68];
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_addr  = addr;
        wb_wdata = wdata;
        wb_sel   = sel;
        @(negedge clk);
        check_val("req_valid", 128'(req_valid), 128'(1'b1));
        check_val("req_payload", 128'(req), 128'(exp_req));
        if (abort_at == 1) begin
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
        end
        for (int unsigned i = 0; i < stall; i++) begin
            if (i == 0) begin
                check_val("resp_ready_in_req", 128'(resp_ready), 128'(1'b0));
                resp_valid = 1'b1;
                resp       = {3'b000, tid, 32'($urandom())};
            end
            @(negedge clk);
            resp_valid = 1'b0;
            check_val("req_valid_stall", 128'(req_valid), 128'(1'b1));
            check_val("req_stable", 128'(req), 128'(exp_req));
            check_quiet("stall");
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        seq_m = (seq_m + 1) % 256;
        check_val("req_valid_after_hs", 128'(req_valid), 128'(1'b0));
        if (abort_at == 2) begin
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
        end
        for (int unsigned i = 0; i < rdly; i++) begin
            check_quiet("resp_wait");
            @(negedge clk);
        end
        check_val("resp_ready_in_resp", 128'(resp_ready), 128'(1'b1));
        resp_valid = 1'b1;
        resp       = {status, (bad_tid ? (tid ^ 16'h0001) : tid), rdata};
        @(negedge clk);
        resp_valid = 1'b0;
        ok       = (status == 3'b000) && !bad_tid;
        want_ack = (abort_at == 0) && ok;
        want_err = (abort_at == 0) && !ok;
        check_val("wb_ack", 128'(wb_ack), 128'(want_ack));
        check_val("wb_err", 128'(wb_err), 128'(want_err));
        check_val("wb_data", 128'(wb_rdata), 128'((want_ack && !we) ? rdata : 32'h0));
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(negedge clk);
        check_quiet("one_cycle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = '0; wb_wdata = '0; wb_sel = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp = '0;
        idle(2);
        check_val("rst_req_valid", 128'(req_valid), 128'(1'b0));
        check_val("rst_req", 128'(req), 128'(0));
        check_val("rst_resp_ready", 128'(resp_ready), 128'(1'b0));
        check_val("rst_data", 128'(wb_rdata), 128'(0));
        check_quiet("rst");
        rst = 1'b0;
        idle(2);

        // Write, immediate handshakes, seq 0
        do_txn(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 3'b000, 1'b0, 32'h0, 0);
        idle(1);
        // Read with 5-cycle ready stall
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 5, 0, 3'b000, 1'b0, 32'h1234_5678, 0);
        idle(1);
        // Error status, then tid mismatch
        do_txn(1'b0, 32'h0000_0200, 32'h0, 4'h3, 1, 2, 3'b010, 1'b0, 32'hAAAA_5555, 0);
        idle(1);
        do_txn(1'b1, 32'h0000_0204, 32'h0BAD_F00D, 4'hC, 0, 1, 3'b000, 1'b1, 32'h0, 0);
        idle(1);
        // Abort in RESP, then a normal read
        do_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 2, 3'b000, 1'b0, 32'h5A5A_5A5A, 2);
        idle(1);
        do_txn(1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'h0F0F_0F0F, 0);

        // Strobe held straight after ack is ignored for one cycle
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_addr = 32'h0000_0400; wb_sel = 4'hF;
        @(negedge clk);
        check_val("holdoff_ignore", 128'(req_valid), 128'(1'b0));
        do_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'h7777_8888, 0);
        idle(1);

        // Stray response in IDLE is drained without a completion
        check_val("stray_ready_idle", 128'(resp_ready), 128'(1'b1));
        resp_valid = 1'b1;
        resp = {3'b000, 16'h01EE, 32'hCAFE_F00D};
        @(negedge clk);
        resp_valid = 1'b0;
        check_quiet("stray_idle");
        idle(1);
        do_txn(1'b1, 32'h0000_0500, 32'h1111_2222, 4'h1, 2, 1, 3'b000, 1'b0, 32'h0, 0);
        idle(1);

        // Reset while a request is pending
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 32'h0000_0600; wb_wdata = 32'h3333_4444; wb_sel = 4'hF;
        @(negedge clk);
        check_val("pre_rst_valid", 128'(req_valid), 128'(1'b1));
        #2 rst = 1'b1;
        #1;
        check_val("midrst_req_valid", 128'(req_valid), 128'(1'b0));
        check_val("midrst_req", 128'(req), 128'(0));
        check_val("midrst_resp_ready", 128'(resp_ready), 128'(1'b0));
        check_quiet("midrst");
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seq_m = 0;
        idle(2);
        do_txn(1'b0, 32'h0000_0700, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'h9999_0000, 0);
        idle(1);

`ifdef RCT_W2M_TIMEOUT_EN
        begin
            int unsigned cnt;
            logic [15:0] stale;
            stale = model_req(1'b0, 32'h0, 32'h0, 4'h0, seq_m)[83:68];
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
            wb_addr = 32'h0000_0800; wb_sel = 4'hF;
            @(negedge clk);
            check_val("tmo_req_valid", 128'(req_valid), 128'(1'b1));
            req_ready = 1'b1;
            @(negedge clk);
            req_ready = 1'b0;
            seq_m = (seq_m + 1) % 256;
            cnt = 0;
            while (!wb_err && cnt < 4 * TMO) begin
                @(negedge clk);
                cnt++;
            end
            check_val("tmo_cycles", 128'(cnt), 128'(TMO));
            check_val("tmo_no_ack", 128'(wb_ack), 128'(1'b0));
            wb_cyc = 1'b0; wb_stb = 1'b0;
            @(negedge clk);
            check_quiet("tmo_after");
            check_val("tmo_late_ready", 128'(resp_ready), 128'(1'b1));
            resp_valid = 1'b1;
            resp = {3'b000, stale, 32'h4444_4444};
            @(negedge clk);
            resp_valid = 1'b0;
            check_quiet("tmo_late");
            idle(1);
            do_txn(1'b0, 32'h0000_0804, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'h2468_ACE0, 0);
            idle(1);
        end
`endif

        // Random traffic; more than 256 transactions so seq wraps
        for (int n = 0; n < 300; n++) begin
            bit          we, bad;
            logic [2:0]  st;
            int unsigned ab;
            we  = 1'($urandom_range(1, 0));
            st  = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
            bad = ($urandom_range(9, 0) == 0);
            ab  = ($urandom_range(11, 0) == 0) ? $urandom_range(2, 1) : 0;
            do_txn(we, 32'($urandom()), 32'($urandom()), 4'($urandom_range(15, 0)),
                   $urandom_range(3, 0), $urandom_range(3, 0), st, bad, 32'($urandom()), ab);
            idle(1 + $urandom_range(1, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
